subtractor_serial_n: RTL and testbench

//  Bit-serial N-bit subtractor: computes diff = a - b - b_in, one bit per clock, LSB first.

---
 rtl/subtractor_serial_n.sv | 135 +++++++++++++
 tb/tb_subtractor_serial_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial_n.sv
// Bit-serial N-bit subtractor: diff = (a - b - b_in) mod 2^N, one bit per clock, LSB first.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/i_ready     operand handshake (i_ready high only in IDLE)
//   a, b, b_in          minuend, subtrahend, borrow in (sampled on the accept edge only)
//   o_valid/o_ready     result handshake (o_valid high only in DONE)
//   diff, b_out, zero   result, borrow out (a < b + b_in), diff == 0
module subtractor_serial_n #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         zero
);

  localparam int unsigned CW = (N < 1) ? 1 : $clog2(N + 1);

  if (N < 1) begin : g_bad_n
    $error("subtractor_serial_n: N must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_sh_q, b_sh_d;
  logic [N-1:0]    res_q, res_d;
  logic            br_q, br_d;
  logic            b_out_q, b_out_d;
  logic            zero_q, zero_d;
  logic            i_ready_q, i_ready_d;
  logic            o_valid_q, o_valid_d;

  // Full-subtractor cell on the current LSBs
  logic bit_c;
  logic br_next_c;

  assign bit_c     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next_c = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    b_out_d = b_out_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid && i_ready_q) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = b_in;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next_c;
        // New bit enters at the MSB so the LSB-first stream lands in place after N shifts
        res_d  = N'({bit_c, res_q} >> 1);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          b_out_d = br_next_c;
          zero_d  = (res_d == '0);
        end
      end
      S_DONE: begin
        if (o_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    i_ready_d = (state_d == S_IDLE);
    o_valid_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_q     <= '0;
      br_q      <= 1'b0;
      b_out_q   <= 1'b0;
      zero_q    <= 1'b1;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_q     <= res_d;
      br_q      <= br_d;
      b_out_q   <= b_out_d;
      zero_q    <= zero_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign diff    = res_q;
  assign b_out   = b_out_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_subtractor_serial_n.sv
// Scoreboard bench for subtractor_serial_n: an N=8 instance and an N=1 instance.
module tb_subtractor_serial_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       iv8 = 1'b0, ir8, bin8 = 1'b0, ov8, or8 = 1'b1, bo8, z8;
  logic [7:0] a8 = '0, b8 = '0, d8;
  // N=1 instance
  logic       iv1 = 1'b0, ir1, bin1 = 1'b0, ov1, or1 = 1'b1, bo1, z1;
  logic [0:0] a1 = '0, b1 = '0, d1;

  subtractor_serial_n #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv8), .i_ready(ir8), .a(a8), .b(b8), .b_in(bin8),
    .o_valid(ov8), .o_ready(or8), .diff(d8), .b_out(bo8), .zero(z8));

  subtractor_serial_n #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv1), .i_ready(ir1), .a(a1), .b(b1), .b_in(bin1),
    .o_valid(ov1), .o_ready(or1), .diff(d1), .b_out(bo1), .zero(z1));

  int tests = 0;
  int fails = 0;

  // Expected {b_out, zero, diff}
  logic [9:0] sb8[$];
  logic [2:0] sb1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - 9'(bi);
    return {r[8], (r[7:0] == 8'h00), r[7:0]};
  endfunction

  // Monitors: pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (sb8.size() == 0) begin
        chk("n8_unexpected_result", 32'(d8), 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = sb8.pop_front();
        chk("n8_result", 32'({bo8, z8, d8}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      if (sb1.size() == 0) begin
        chk("n1_unexpected_result", 32'(d1), 32'hFFFF_FFFF);
      end else begin
        logic [2:0] e;
        e = sb1.pop_front();
        chk("n1_result", 32'({bo1, z1, d1}), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one N=8 operation; returns after the accept edge (+1)
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int n = 0;
    while (!ir8 && n < 100) begin tick(); n++; end
    if (!ir8) chk("n8_i_ready_timeout", 32'(ir8), 32'd1);
    a8 = a; b8 = b; bin8 = bi; iv8 = 1'b1;
    sb8.push_back(model8(a, b, bi));
    tick();
    iv8 = 1'b0;
    // Operands must have been captured; scramble them
    a8 = ~a; b8 = a ^ b; bin8 = ~bi;
  endtask

  // Wait for o_valid, return cycles counted since the accept edge
  task automatic wait_ov8(output int cyc);
    cyc = 0;
    while (!ov8 && cyc < 100) begin tick(); cyc++; end
    if (!ov8) chk("n8_o_valid_timeout", 32'(ov8), 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic chk_lat);
    int cyc;
    issue8(a, b, bi);
    wait_ov8(cyc);
    if (chk_lat) chk("n8_latency", 32'(cyc), 32'd8);
    tick(); // handshake edge
  endtask

  initial begin
    int cyc;
    logic [9:0] snap;

    // Reset state
    #12;
    chk("rst_i_ready", 32'(ir8), 32'd1);
    chk("rst_o_valid", 32'(ov8), 32'd0);
    chk("rst_diff", 32'(d8), 32'd0);
    chk("rst_b_out", 32'(bo8), 32'd0);
    chk("rst_zero", 32'(z8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    op8(8'h05, 8'h03, 1'b0, 1'b1);
    op8(8'h03, 8'h05, 1'b0, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 1'b1);
    op8(8'hA5, 8'hA5, 1'b0, 1'b1);
    op8(8'hFF, 8'h00, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b0);
    op8(8'h00, 8'hFF, 1'b1, 1'b0);
    chk("idle_after_handoff", 32'(ir8), 32'd1);

    // Random vectors
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    // Backpressure: hold o_ready low in DONE, pulse i_valid meanwhile
    or8 = 1'b0;
    issue8(8'h3C, 8'h5A, 1'b1);
    wait_ov8(cyc);
    chk("bp_latency", 32'(cyc), 32'd8);
    snap = model8(8'h3C, 8'h5A, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin a8 = 8'h11; b8 = 8'h22; bin8 = 1'b0; iv8 = 1'b1; end
      if (k == 6) iv8 = 1'b0;
      chk("bp_hold", 32'({ov8, ir8, bo8, z8, d8}), 32'({1'b1, 1'b0, snap}));
      tick();
    end
    or8 = 1'b1;
    tick();
    chk("bp_release_i_ready", 32'(ir8), 32'd1);
    chk("bp_release_o_valid", 32'(ov8), 32'd0);

    // Reset in the middle of RUN (counter = 4)
    issue8(8'hC3, 8'h42, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_i_ready", 32'(ir8), 32'd1);
    chk("midrst_o_valid", 32'(ov8), 32'd0);
    chk("midrst_diff", 32'(d8), 32'd0);
    chk("midrst_zero", 32'(z8), 32'd1);
    chk("midrst_b_out", 32'(bo8), 32'd0);
    sb8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    op8(8'h10, 8'h20, 1'b1, 1'b1);

    // N=1 single op: latency 1
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; iv1 = 1'b1;
    sb1.push_back({1'b1, 1'b0, 1'b1});
    tick();
    iv1 = 1'b0;
    chk("n1_latency_pre", 32'(ov1), 32'd0);
    tick();
    chk("n1_latency", 32'(ov1), 32'd1);
    tick();

    // N=1 back-to-back with o_ready high: i_ready 1,0,0 repeating
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b1; iv1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("n1_i_ready_pattern", 32'(ir1), ((k % 3) == 0) ? 32'd1 : 32'd0);
      if (ir1) sb1.push_back({1'b0, 1'b1, 1'b0});
      tick();
    end
    iv1 = 1'b0;
    repeat (3) tick();

    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
